// File: rtl/pa_ifu_sram512x16_ctrl_pkg.sv
// rtl/pa_ifu_sram512x16_ctrl_pkg.sv - shared constants and FSM encoding for the IFU SRAM controller
package pa_ifu_sram512x16_ctrl_pkg;

    localparam int ADDR_WIDTH   = 9;
    localparam int DATA_WIDTH   = 16;
    localparam int SRAM_DEPTH   = 2 ** ADDR_WIDTH;
    localparam int WR_BURST_DEF = 2;

    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(SRAM_DEPTH - 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/pa_ifu_sram512x16_ctrl_if.sv
// rtl/pa_ifu_sram512x16_ctrl_if.sv - fetch/refill/invalidate requests plus the SRAM macro pins
interface pa_ifu_sram512x16_ctrl_if;
    import pa_ifu_sram512x16_ctrl_pkg::*;

    logic                  inv_req;
    logic                  inv_busy;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_data_vld;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] wr_bmask;
    logic                  wr_gnt;
    logic [ADDR_WIDTH-1:0] sram_a;
    logic                  sram_cen;
    logic                  sram_gwen;
    logic [DATA_WIDTH-1:0] sram_wen;
    logic [DATA_WIDTH-1:0] sram_d;
    logic [DATA_WIDTH-1:0] sram_q;

    modport slave (
        input  inv_req, rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_bmask, sram_q,
        output inv_busy, rd_gnt, rd_data_vld, rd_data, wr_gnt,
               sram_a, sram_cen, sram_gwen, sram_wen, sram_d
    );

    modport master (
        output inv_req, rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_bmask, sram_q,
        input  inv_busy, rd_gnt, rd_data_vld, rd_data, wr_gnt,
               sram_a, sram_cen, sram_gwen, sram_wen, sram_d
    );

endinterface

// File: rtl/pa_ifu_sram_arb_rr.sv
// rtl/pa_ifu_sram_arb_rr.sv - write-priority read/write arbiter with a bounded write streak
module pa_ifu_sram_arb_rr #(
    parameter int WR_BURST = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_en,
    input  logic i_rd_req,
    input  logic i_wr_req,
    output logic o_rd_gnt,
    output logic o_wr_gnt
);

    localparam int SW = (WR_BURST < 1) ? 1 : $clog2(WR_BURST + 1);

    logic [SW-1:0] r_streak;
    logic          w_streak_full;

    // Once a pending read has watched WR_BURST writes go by, it takes the next slot.
    assign w_streak_full = (r_streak == SW'(WR_BURST));
    assign o_wr_gnt      = i_en & i_wr_req & ~(i_rd_req & w_streak_full);
    assign o_rd_gnt      = i_en & i_rd_req & (~i_wr_req | w_streak_full);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_streak <= '0;
        end else if (o_rd_gnt || !i_rd_req) begin
            r_streak <= '0;
        end else if (o_wr_gnt && !w_streak_full) begin
            r_streak <= r_streak + SW'(1);
        end
    end

endmodule

// File: rtl/pa_ifu_sram512x16_ctrl.sv
// rtl/pa_ifu_sram512x16_ctrl.sv - clear sweep FSM and fetch/refill sequencing for a 512x16 SRAM
module pa_ifu_sram512x16_ctrl
    import pa_ifu_sram512x16_ctrl_pkg::*;
#(
    parameter int WR_BURST = WR_BURST_DEF
) (
    input  logic                     forever_cpuclk,
    input  logic                     cpurst_b,
    pa_ifu_sram512x16_ctrl_if.slave  bus
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  r_rd_data_vld;
    logic                  w_run;
    logic                  w_clr_last;
    logic                  w_rd_gnt;
    logic                  w_wr_gnt;
    logic                  w_cen;
    logic                  w_gwen;
    logic [DATA_WIDTH-1:0] w_wen;
    logic [ADDR_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_d;

    assign w_run      = (r_state == ST_RUN) & cpurst_b;
    assign w_clr_last = (r_clr_cnt == CLR_LAST);

    pa_ifu_sram_arb_rr #(.WR_BURST(WR_BURST)) u_arb (
        .i_clk    (forever_cpuclk),
        .i_rstn   (cpurst_b),
        .i_en     (w_run),
        .i_rd_req (bus.rd_req),
        .i_wr_req (bus.wr_req),
        .o_rd_gnt (w_rd_gnt),
        .o_wr_gnt (w_wr_gnt)
    );

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (w_clr_last) w_state_nxt = ST_RUN;
            ST_RUN:   if (bus.inv_req) w_state_nxt = ST_CLEAR;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    // The counter wraps to zero exactly as the sweep hands over to RUN.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + ADDR_WIDTH'(1);
        end else if (bus.inv_req) begin
            r_clr_cnt <= '0;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_rd_data_vld <= 1'b0;
        end else begin
            r_rd_data_vld <= w_rd_gnt;
        end
    end

    always_comb begin
        w_cen  = 1'b1;
        w_gwen = 1'b1;
        w_wen  = '1;
        w_a    = '0;
        w_d    = '0;
        if (!cpurst_b) begin
            w_cen = 1'b1;
        end else if (r_state == ST_CLEAR) begin
            w_cen  = 1'b0;
            w_gwen = 1'b0;
            w_wen  = '0;
            w_a    = r_clr_cnt;
        end else if (w_wr_gnt) begin
            w_cen  = 1'b0;
            w_gwen = 1'b0;
            w_wen  = ~bus.wr_bmask;
            w_a    = bus.wr_addr;
            w_d    = bus.wr_data;
        end else if (w_rd_gnt) begin
            w_cen  = 1'b0;
            w_a    = bus.rd_addr;
        end
    end

    assign bus.sram_cen    = w_cen;
    assign bus.sram_gwen   = w_gwen;
    assign bus.sram_wen    = w_wen;
    assign bus.sram_a      = w_a;
    assign bus.sram_d      = w_d;
    assign bus.rd_gnt      = w_rd_gnt;
    assign bus.wr_gnt      = w_wr_gnt;
    assign bus.inv_busy    = (r_state == ST_CLEAR) | ~cpurst_b;
    assign bus.rd_data_vld = r_rd_data_vld & cpurst_b;
    assign bus.rd_data     = bus.sram_q;

endmodule

// File: tb/tb_pa_ifu_sram512x16_ctrl.sv
// tb/tb_pa_ifu_sram512x16_ctrl.sv - directed vector bench with a behavioural 512x16 SRAM
module tb_pa_ifu_sram512x16_ctrl;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_errors;

    pa_ifu_sram512x16_ctrl_if u_if();

    pa_ifu_sram512x16_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rstn),
        .bus            (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port macro: active-low controls, bit-masked write, registered Q.
    logic [15:0] mem [512];
    initial for (int i = 0; i < 512; i++) mem[i] = 16'hDEAD;
    initial u_if.sram_q = 16'h0;
    always @(posedge clk) begin
        if (!u_if.sram_cen) begin
            if (!u_if.sram_gwen)
                mem[u_if.sram_a] <= (mem[u_if.sram_a] & u_if.sram_wen) | (u_if.sram_d & ~u_if.sram_wen);
            else
                u_if.sram_q <= mem[u_if.sram_a];
        end
    end

    typedef struct {
        logic        rd_req;
        logic [8:0]  rd_addr;
        logic        wr_req;
        logic [8:0]  wr_addr;
        logic [15:0] wr_data;
        logic [15:0] wr_bmask;
        logic        e_rd_gnt;
        logic        e_wr_gnt;
        logic        e_cen;
        logic        e_gwen;
        logic [15:0] e_wen;
        logic [8:0]  e_a;
        logic [15:0] e_d;
        logic        e_vld;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        u_if.inv_req  = 1'b0;
        u_if.rd_req   = 1'b0;
        u_if.rd_addr  = 9'h0;
        u_if.wr_req   = 1'b0;
        u_if.wr_addr  = 9'h0;
        u_if.wr_data  = 16'h0;
        u_if.wr_bmask = 16'h0;
    endtask

    // Starts in the first sweep cycle; requests are held high to show they are blocked.
    task automatic run_sweep(input int inv_at);
        int bad;
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            u_if.inv_req = (i == inv_at);
            u_if.rd_req  = 1'b1;
            u_if.wr_req  = 1'b1;
            @(negedge clk);
            if (u_if.sram_a !== 9'(i) || u_if.sram_cen !== 1'b0 || u_if.sram_gwen !== 1'b0 ||
                u_if.sram_wen !== 16'h0 || u_if.sram_d !== 16'h0 || u_if.inv_busy !== 1'b1 ||
                u_if.rd_gnt !== 1'b0 || u_if.wr_gnt !== 1'b0)
                bad++;
            next_cycle();
        end
        check("sweep_cycle_errors", 32'(bad), 32'd0);
        idle_inputs();
        @(negedge clk);
        check("sweep_done_busy", {31'd0, u_if.inv_busy}, 32'd0);
        check("sweep_done_cen", {31'd0, u_if.sram_cen}, 32'd1);
        next_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        string pat;
        n_checks = 0;
        n_errors = 0;
        //            rd  rd_addr wr  wr_addr  wr_data   bmask     rg wg cen gwen wen       a       d         vld rdata
        vecs[0]  = '{1'b0, 9'h000, 1'b0, 9'h000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 9'h000, 16'h0000, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 9'h000, 1'b1, 9'h005, 16'hA5A5, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 9'h005, 16'hA5A5, 1'b0, 16'h0000};
        vecs[2]  = '{1'b1, 9'h005, 1'b0, 9'h000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 9'h005, 16'h0000, 1'b0, 16'h0000};
        vecs[3]  = '{1'b0, 9'h000, 1'b0, 9'h000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 9'h000, 16'h0000, 1'b1, 16'hA5A5};
        vecs[4]  = '{1'b0, 9'h000, 1'b1, 9'h1FF, 16'hFFFF, 16'h00F0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFF0F, 9'h1FF, 16'hFFFF, 1'b0, 16'h0000};
        vecs[5]  = '{1'b1, 9'h1FF, 1'b0, 9'h000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 9'h1FF, 16'h0000, 1'b0, 16'h0000};
        vecs[6]  = '{1'b0, 9'h000, 1'b0, 9'h000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 9'h000, 16'h0000, 1'b1, 16'h00F0};
        vecs[7]  = '{1'b0, 9'h000, 1'b1, 9'h010, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 9'h010, 16'h1234, 1'b0, 16'h0000};
        vecs[8]  = '{1'b1, 9'h010, 1'b0, 9'h000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 9'h010, 16'h0000, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 9'h000, 1'b0, 9'h000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 9'h000, 16'h0000, 1'b1, 16'h0000};
        vecs[10] = '{1'b1, 9'h020, 1'b1, 9'h020, 16'hBEEF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 9'h020, 16'hBEEF, 1'b0, 16'h0000};
        vecs[11] = '{1'b1, 9'h020, 1'b0, 9'h000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 9'h020, 16'h0000, 1'b0, 16'h0000};
        vecs[12] = '{1'b0, 9'h000, 1'b0, 9'h000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 9'h000, 16'h0000, 1'b1, 16'hBEEF};

        idle_inputs();
        rstn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_cen_gwen", {30'd0, u_if.sram_cen, u_if.sram_gwen}, 32'd3);
        check("rst_wen", {16'd0, u_if.sram_wen}, 32'h0000FFFF);
        check("rst_busy_gnt_vld", {28'd0, u_if.inv_busy, u_if.rd_gnt, u_if.wr_gnt, u_if.rd_data_vld}, 32'h8);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Power-on sweep with an ignored invalidate at count 100.
        run_sweep(100);

        for (int v = 0; v < 13; v++) begin
            u_if.rd_req   = vecs[v].rd_req;
            u_if.rd_addr  = vecs[v].rd_addr;
            u_if.wr_req   = vecs[v].wr_req;
            u_if.wr_addr  = vecs[v].wr_addr;
            u_if.wr_data  = vecs[v].wr_data;
            u_if.wr_bmask = vecs[v].wr_bmask;
            @(negedge clk);
            check($sformatf("v%0d_ctl", v),
                  {27'd0, u_if.rd_gnt, u_if.wr_gnt, u_if.sram_cen, u_if.sram_gwen, u_if.rd_data_vld},
                  {27'd0, vecs[v].e_rd_gnt, vecs[v].e_wr_gnt, vecs[v].e_cen, vecs[v].e_gwen, vecs[v].e_vld});
            check($sformatf("v%0d_wen", v), {16'd0, u_if.sram_wen}, {16'd0, vecs[v].e_wen});
            check($sformatf("v%0d_a", v), {23'd0, u_if.sram_a}, {23'd0, vecs[v].e_a});
            if (!vecs[v].e_rd_gnt)
                check($sformatf("v%0d_d", v), {16'd0, u_if.sram_d}, {16'd0, vecs[v].e_d});
            if (vecs[v].e_vld)
                check($sformatf("v%0d_rdata", v), {16'd0, u_if.rd_data}, {16'd0, vecs[v].e_rdata});
            next_cycle();
        end

        // Continuous contention: write streak bounded at two.
        pat = "";
        u_if.rd_req = 1'b1; u_if.rd_addr = 9'h040;
        u_if.wr_req = 1'b1; u_if.wr_addr = 9'h040; u_if.wr_data = 16'h1111; u_if.wr_bmask = 16'hFFFF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (u_if.wr_gnt && !u_if.rd_gnt) pat = {pat, "W"};
            else if (u_if.rd_gnt && !u_if.wr_gnt) pat = {pat, "R"};
            else pat = {pat, "x"};
            next_cycle();
        end
        check("contention_pattern", 32'(pat == "WWRWWR"), 32'd1);
        if (pat != "WWRWWR") $display("FAIL contention_seq actual=%s expected=WWRWWR", pat);
        idle_inputs();

        // Invalidate in RUN alongside a write: that write is still granted.
        u_if.inv_req = 1'b1;
        u_if.wr_req = 1'b1; u_if.wr_addr = 9'h030; u_if.wr_data = 16'h7777; u_if.wr_bmask = 16'hFFFF;
        @(negedge clk);
        check("inv_cycle_wr_gnt", {30'd0, u_if.wr_gnt, u_if.inv_busy}, 32'd2);
        next_cycle();
        idle_inputs();
        run_sweep(-1);

        u_if.rd_req = 1'b1; u_if.rd_addr = 9'h005;
        @(negedge clk);
        check("post_inv_rd_gnt", {31'd0, u_if.rd_gnt}, 32'd1);
        next_cycle();
        u_if.rd_req = 1'b0;
        @(negedge clk);
        check("post_inv_vld", {31'd0, u_if.rd_data_vld}, 32'd1);
        check("post_inv_rdata", {16'd0, u_if.rd_data}, 32'h0);
        next_cycle();

        // Reset the cycle after a read grant: pending valid dropped, sweep restarts at 0.
        u_if.rd_req = 1'b1; u_if.rd_addr = 9'h030;
        @(negedge clk);
        check("mid_rd_gnt", {31'd0, u_if.rd_gnt}, 32'd1);
        next_cycle();
        u_if.rd_req = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        check("mid_rst_vld_cen", {29'd0, u_if.rd_data_vld, u_if.sram_cen, u_if.inv_busy}, 32'd3);
        next_cycle();
        rstn = 1'b1;
        @(negedge clk);
        check("restart_a0", {22'd0, u_if.sram_cen, u_if.sram_a}, 32'd0);
        check("restart_vld_busy", {30'd0, u_if.rd_data_vld, u_if.inv_busy}, 32'd1);
        next_cycle();
        @(negedge clk);
        check("restart_a1", {23'd0, u_if.sram_a}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
